// File: rtl/small_calc_cu.sv
// small_calc_cu: Moore control unit for the small calculator datapath.
// On a go request it clears the result register, loads operands A and B,
// executes the ALU op into the result register and then presents the result
// until go is released (4-phase go/done handshake).
module small_calc_cu #(
  parameter logic [1:0] A_ADDR = 2'd1,
  parameter logic [1:0] B_ADDR = 2'd2,
  parameter logic [1:0] R_ADDR = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic       rea,
  output logic [1:0] rab,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Mux1 select encodings
  localparam logic [1:0] SEL_IN1  = 2'b00;
  localparam logic [1:0] SEL_IN2  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_ALU  = 2'b11;

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;

  // Next-state logic; op is captured only when leaving IDLE so later changes are ignored
  always_comb begin
    state_d = S_IDLE;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_CLEAR;
          op_d    = op;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR:  state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_DONE;
      S_DONE:   state_d = go ? S_DONE : S_IDLE;
      default:  state_d = S_IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // State and latched opcode registers; reset forces IDLE immediately, which also drops we
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Pure Moore output decode of the current state and latched opcode
  always_comb begin
    s1   = 2'b00;
    wa   = 2'b00;
    we   = 1'b0;
    raa  = 2'b00;
    rea  = 1'b0;
    rab  = 2'b00;
    reb  = 1'b0;
    c    = 2'b00;
    s2   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_CLEAR: begin
        s1   = SEL_ZERO;
        wa   = R_ADDR;
        we   = 1'b1;
        busy = 1'b1;
      end
      S_LOAD_A: begin
        s1   = SEL_IN1;
        wa   = A_ADDR;
        we   = 1'b1;
        busy = 1'b1;
      end
      S_LOAD_B: begin
        s1   = SEL_IN2;
        wa   = B_ADDR;
        we   = 1'b1;
        busy = 1'b1;
      end
      S_EXEC: begin
        rea  = 1'b1;
        raa  = A_ADDR;
        reb  = 1'b1;
        rab  = B_ADDR;
        c    = op_q;
        s1   = SEL_ALU;
        wa   = R_ADDR;
        we   = 1'b1;
        busy = 1'b1;
      end
      S_DONE: begin
        // Keep the ALU fed from the operand registers so out stays stable
        rea  = 1'b1;
        raa  = A_ADDR;
        reb  = 1'b1;
        rab  = B_ADDR;
        c    = op_q;
        s2   = 1'b1;
        done = 1'b1;
      end
      default: begin
        s1 = 2'b00;
      end
    endcase
  end

  assign state = state_q;

endmodule
